// File: rtl/array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : array_ctrl
// Brief    : Job sequencer for the HEIGHT x WIDTH unary GEMM systolic array.
//            Optional counters under macro ARRAY_CTRL_PERF_EN.
// Revision : 1.0  initial release
// ============================================================================
module array_ctrl #(
    parameter int HEIGHT = 32,
    parameter int WIDTH  = 32,
    parameter int IWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CWIDTH-1:0]   num_tiles,
    input  logic [IWIDTH-1:0]   mac_cycles,
    output logic                busy,
    output logic                done,
    output logic                wght_rd,
    output logic [HEIGHT-1:0]   ifm_rd,
    output logic                ofm_valid,
    output logic [HEIGHT-1:0]   en_i,
    output logic [HEIGHT-1:0]   clr_i,
    output logic [HEIGHT-1:0]   mac_done,
    output logic [WIDTH-1:0]    en_w,
    output logic [WIDTH-1:0]    clr_w,
    output logic [WIDTH-1:0]    en_o,
    output logic [WIDTH-1:0]    clr_o
`ifdef ARRAY_CTRL_PERF_EN
    ,
    output logic [2*CWIDTH-1:0] perf_cycles,
    output logic [CWIDTH-1:0]   perf_tiles
`endif
);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_CLR_ALL = 3'd1;
    localparam logic [2:0] c_S_LOAD_W  = 3'd2;
    localparam logic [2:0] c_S_COMPUTE = 3'd3;
    localparam logic [2:0] c_S_DRAIN   = 3'd4;
    localparam logic [2:0] c_S_CLR_O   = 3'd5;
    localparam logic [2:0] c_S_DONE    = 3'd6;

    localparam logic [IWIDTH-1:0] c_MC_MAX     = {1'b1, {(IWIDTH-1){1'b0}}};
    localparam logic [CWIDTH-1:0] c_LOAD_LAST  = CWIDTH'(HEIGHT - 1);
    localparam logic [CWIDTH-1:0] c_DRAIN_LAST = CWIDTH'(HEIGHT + WIDTH - 2);
    localparam logic [CWIDTH-1:0] c_OFM_FIRST  = CWIDTH'(WIDTH - 1);
    localparam logic [CWIDTH-1:0] c_SKEW_M2    = CWIDTH'(HEIGHT - 2);

    logic [2:0]        state_q, state_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic [CWIDTH-1:0] tile_q, tile_d;
    logic [CWIDTH-1:0] ntiles_q, ntiles_d;
    logic [IWIDTH-1:0] mcyc_q, mcyc_d;
    logic [CWIDTH-1:0] mcyc_ext;
    logic [CWIDTH-1:0] win_last;
    logic [CWIDTH-1:0] row_lo;

    logic              busy_d, done_d, wght_rd_d, ofm_valid_d;
    logic [HEIGHT-1:0] en_i_d, clr_i_d, mac_done_d;
    logic [WIDTH-1:0]  en_w_d, clr_w_d, en_o_d, clr_o_d;

    assign mcyc_ext = CWIDTH'(mcyc_q);
    // Last local cycle of the skewed compute window: mac_cycles + HEIGHT - 2.
    assign win_last = mcyc_ext + c_SKEW_M2;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CWIDTH'(1);
        tile_d   = tile_q;
        ntiles_d = ntiles_q;
        mcyc_d   = mcyc_q;
        case (state_q)
            c_S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d  = c_S_CLR_ALL;
                    tile_d   = '0;
                    ntiles_d = num_tiles;
                    if (mac_cycles == '0) begin
                        mcyc_d = IWIDTH'(1);
                    end else if (mac_cycles > c_MC_MAX) begin
                        mcyc_d = c_MC_MAX;
                    end else begin
                        mcyc_d = mac_cycles;
                    end
                end
            end
            c_S_CLR_ALL: begin
                state_d = c_S_LOAD_W;
                cnt_d   = '0;
            end
            c_S_LOAD_W: begin
                if (cnt_q == c_LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = (ntiles_q != '0) ? c_S_COMPUTE : c_S_DONE;
                end
            end
            c_S_COMPUTE: begin
                if (cnt_q == win_last) begin
                    cnt_d   = '0;
                    state_d = c_S_DRAIN;
                end
            end
            c_S_DRAIN: begin
                if (cnt_q == c_DRAIN_LAST) begin
                    cnt_d   = '0;
                    tile_d  = tile_q + CWIDTH'(1);
                    state_d = (tile_d == ntiles_q) ? c_S_DONE : c_S_CLR_O;
                end
            end
            c_S_CLR_O: begin
                state_d = c_S_COMPUTE;
                cnt_d   = '0;
            end
            c_S_DONE: begin
                state_d = c_S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = c_S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the state being entered and registered with it.
    // busy spans the DONE cycle so the job length includes the completion pulse.
    always_comb begin
        row_lo      = '0;
        busy_d      = (state_d != c_S_IDLE);
        done_d      = (state_d == c_S_DONE);
        wght_rd_d   = (state_d == c_S_LOAD_W);
        ofm_valid_d = (state_d == c_S_DRAIN) && (cnt_d >= c_OFM_FIRST);
        en_w_d      = {WIDTH{state_d == c_S_LOAD_W}};
        clr_w_d     = {WIDTH{state_d == c_S_CLR_ALL}};
        en_o_d      = {WIDTH{state_d == c_S_DRAIN}};
        clr_o_d     = {WIDTH{(state_d == c_S_CLR_ALL) || (state_d == c_S_CLR_O)}};
        clr_i_d     = {HEIGHT{(state_d == c_S_CLR_ALL) || (state_d == c_S_CLR_O)}};
        en_i_d      = '0;
        mac_done_d  = '0;
        for (int h = 0; h < HEIGHT; h++) begin
            row_lo        = CWIDTH'(h);
            en_i_d[h]     = (state_d == c_S_COMPUTE) && (cnt_d >= row_lo)
                            && (cnt_d < row_lo + mcyc_ext);
            mac_done_d[h] = (state_d == c_S_COMPUTE)
                            && (cnt_d == row_lo + mcyc_ext - CWIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_S_IDLE;
            cnt_q     <= '0;
            tile_q    <= '0;
            ntiles_q  <= '0;
            mcyc_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wght_rd   <= 1'b0;
            ofm_valid <= 1'b0;
            ifm_rd    <= '0;
            en_i      <= '0;
            clr_i     <= '0;
            mac_done  <= '0;
            en_w      <= '0;
            clr_w     <= '0;
            en_o      <= '0;
            clr_o     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tile_q    <= tile_d;
            ntiles_q  <= ntiles_d;
            mcyc_q    <= mcyc_d;
            busy      <= busy_d;
            done      <= done_d;
            wght_rd   <= wght_rd_d;
            ofm_valid <= ofm_valid_d;
            ifm_rd    <= en_i_d;
            en_i      <= en_i_d;
            clr_i     <= clr_i_d;
            mac_done  <= mac_done_d;
            en_w      <= en_w_d;
            clr_w     <= clr_w_d;
            en_o      <= en_o_d;
            clr_o     <= clr_o_d;
        end
    end

`ifdef ARRAY_CTRL_PERF_EN
    logic [2*CWIDTH-1:0] perf_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q <= '0;
        end else if ((state_q == c_S_IDLE) && start) begin
            perf_cycles_q <= '0;
        end else if (busy && (perf_cycles_q != '1)) begin
            perf_cycles_q <= perf_cycles_q + (2*CWIDTH)'(1);
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_tiles  = tile_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_array_ctrl
// Brief    : Self-checking bench for array_ctrl (HEIGHT=WIDTH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_array_ctrl;

    localparam int H  = 4;
    localparam int W  = 4;
    localparam int IW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_tiles;
    logic [IW-1:0] mac_cycles;
    logic          busy, done, wght_rd, ofm_valid;
    logic [H-1:0]  ifm_rd, en_i, clr_i, mac_done;
    logic [W-1:0]  en_w, clr_w, en_o, clr_o;
`ifdef ARRAY_CTRL_PERF_EN
    logic [2*CW-1:0] perf_cycles;
    logic [CW-1:0]   perf_tiles;
`endif
    logic [35:0]   all_outs;

    assign all_outs = {busy, done, wght_rd, ofm_valid, ifm_rd, en_i, clr_i,
                       mac_done, en_w, clr_w, en_o, clr_o};

    array_ctrl #(.HEIGHT(H), .WIDTH(W), .IWIDTH(IW), .CWIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_tiles  (num_tiles),
        .mac_cycles (mac_cycles),
        .busy       (busy),
        .done       (done),
        .wght_rd    (wght_rd),
        .ifm_rd     (ifm_rd),
        .ofm_valid  (ofm_valid),
        .en_i       (en_i),
        .clr_i      (clr_i),
        .mac_done   (mac_done),
        .en_w       (en_w),
        .clr_w      (clr_w),
        .en_o       (en_o),
        .clr_o      (clr_o)
`ifdef ARRAY_CTRL_PERF_EN
        ,
        .perf_cycles(perf_cycles),
        .perf_tiles (perf_tiles)
`endif
    );

    always #5 clk = ~clk;

    // One job: inputs plus the expected per-job observations.
    typedef struct {
        int nt;      // num_tiles
        int mc;      // mac_cycles as driven
        int busy;    // busy cycles
        int en_cnt;  // en_i cycles per row
        int md_cnt;  // mac_done pulses per row
        int ofm;     // ofm_valid cycles
        int clro;    // CLR_O cycles
        int drains;  // DRAIN phases
        int en3;     // cycle of first en_i[3] (cycle 0 = CLR_ALL)
        int md3;     // cycle of first mac_done[3]
        bit coin;    // en_i must equal mac_done every cycle
    } vec_t;

    vec_t vecs[6];
    vec_t sb_q[$];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        int   k, busy_c, done_c, done_k, wr_c, enw_c, ofm_c, clro_c, drains, en3, md3, errs;
        int   en_c[H];
        int   md_c[H];
        bit   prev_eo;
        vec_t e;
        for (int h = 0; h < H; h++) begin
            en_c[h] = 0;
            md_c[h] = 0;
        end
        busy_c = 0; done_c = 0; done_k = -1; wr_c = 0; enw_c = 0; ofm_c = 0;
        clro_c = 0; drains = 0; en3 = -1; md3 = -1; errs = 0; prev_eo = 1'b0;

        @(negedge clk);
        num_tiles  = CW'(v.nt);
        mac_cycles = IW'(v.mc);
        start      = 1'b1;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef ARRAY_CTRL_PERF_EN
        chk("perf_cycles_clear", 64'(perf_cycles), 64'd0);
        chk("perf_tiles_clear", 64'(perf_tiles), 64'd0);
`endif
        k = 0;
        while (done_k < 0 && k < 2000) begin
            if (busy) busy_c++;
            if (done) begin
                done_c++;
                done_k = k;
            end
            if (wght_rd) wr_c++;
            if (en_w == 4'hF) enw_c++;
            if (ofm_valid) ofm_c++;
            if (clr_o[0] && !clr_w[0]) clro_c++;
            if (en_o[0] && !prev_eo) drains++;
            prev_eo = en_o[0];
            for (int h = 0; h < H; h++) begin
                en_c[h] += int'(en_i[h]);
                md_c[h] += int'(mac_done[h]);
            end
            if (en_i[3] && en3 < 0) en3 = k;
            if (mac_done[3] && md3 < 0) md3 = k;
            if (ifm_rd !== en_i) errs++;
            if ((en_i & clr_i) != '0 || (en_w & clr_w) != '0 || (en_o & clr_o) != '0) errs++;
            if (v.coin && (en_i !== mac_done)) errs++;
            @(posedge clk);
            #1;
            k++;
        end

        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk("done_seen", 64'(done_k >= 0), 64'd1);
            chk("done_cycle", 64'(done_k), 64'(e.busy - 1));
            chk("done_pulses", 64'(done_c), 64'd1);
            chk("busy_cycles", 64'(busy_c), 64'(e.busy));
            chk("busy_after", 64'(busy), 64'd0);
            chk("wght_rd_count", 64'(wr_c), 64'd4);
            chk("load_w_cycles", 64'(enw_c), 64'd4);
            chk("ofm_valid_count", 64'(ofm_c), 64'(e.ofm));
            chk("clr_o_phases", 64'(clro_c), 64'(e.clro));
            chk("drain_phases", 64'(drains), 64'(e.drains));
            for (int h = 0; h < H; h++) begin
                chk($sformatf("en_i_count[%0d]", h), 64'(en_c[h]), 64'(e.en_cnt));
                chk($sformatf("mac_done_count[%0d]", h), 64'(md_c[h]), 64'(e.md_cnt));
            end
            chk("first_en_i3", 64'(en3), 64'(e.en3));
            chk("first_mac_done3", 64'(md3), 64'(e.md3));
            chk("per_cycle_rules", 64'(errs), 64'd0);
`ifdef ARRAY_CTRL_PERF_EN
            chk("perf_cycles_final", 64'(perf_cycles), 64'(e.busy));
            chk("perf_tiles_final", 64'(perf_tiles), 64'(e.nt));
`endif
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k, done_c, enw_c, en0_c, busy_c;

        //          nt  mc  busy en  md ofm clro dr en3 md3 coin
        vecs[0] = '{1,   8,  24,  8, 1,  4,  0, 1,  8, 15, 1'b0};
        vecs[1] = '{3,   2,  44,  6, 3, 12,  2, 3,  8,  9, 1'b0};
        vecs[2] = '{0,   5,   6,  0, 0,  0,  0, 0, -1, -1, 1'b0};
        vecs[3] = '{2,   0,  29,  2, 2,  8,  1, 2,  8,  8, 1'b1};
        vecs[4] = '{1, 200, 144,128, 1,  4,  0, 1,  8,135, 1'b0};
        vecs[5] = '{2, 129, 283,256, 2,  8,  1, 2,  8,135, 1'b0};

        rst = 1'b1; start = 1'b0; num_tiles = '0; mac_cycles = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(all_outs), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_outputs", 64'(all_outs), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i]);
        end

        // Second start during COMPUTE is ignored; reset in DRAIN abandons the job.
        @(negedge clk);
        num_tiles = CW'(1); mac_cycles = IW'(8); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0; done_c = 0; enw_c = 0; en0_c = 0;
        while (!en_o[0] && k < 200) begin
            if (en_w[0]) enw_c++;
            if (done) done_c++;
            if (en_i[0] && en0_c == 0) begin
                start = 1'b1; num_tiles = CW'(5); mac_cycles = IW'(3);
            end else begin
                start = 1'b0;
            end
            if (en_i[0]) en0_c++;
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        chk("irq_reached_drain", 64'(en_o[0]), 64'd1);
        chk("irq_en_i0_len", 64'(en0_c), 64'd8);
        chk("irq_load_w_once", 64'(enw_c), 64'd4);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("irq_reset_outputs", 64'(all_outs), 64'd0);
`ifdef ARRAY_CTRL_PERF_EN
        chk("irq_reset_perf", 64'(perf_cycles), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        busy_c = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) done_c++;
            if (busy) busy_c++;
        end
        chk("irq_no_done", 64'(done_c), 64'd0);
        chk("irq_stays_idle", 64'(busy_c), 64'd0);

        run_job(vecs[0]);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
